// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - handshaked load/store unit with split misaligned beats
module riscv_lsu #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_req_valid,
    output logic                O_req_ready,
    input  logic                I_req_we,
    input  logic [2:0]          I_req_funct3,
    input  logic [ADDR_W-1:0]   I_req_addr,
    input  logic [XLEN-1:0]     I_req_wdata,
    input  logic [4:0]          I_req_rd,
    output logic                O_rsp_valid,
    output logic [XLEN-1:0]     O_rsp_rdata,
    output logic [4:0]          O_rsp_rd,
    output logic                O_rsp_err,
    output logic                O_mem_valid,
    input  logic                I_mem_ready,
    output logic [ADDR_W-1:0]   O_mem_addr,
    output logic                O_mem_we,
    output logic [XLEN/8-1:0]   O_mem_wmask,
    output logic [XLEN-1:0]     O_mem_wdata,
    input  logic                I_mem_rvalid,
    input  logic [XLEN-1:0]     I_mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RSP,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [OFF_W-1:0]    r_off;
    logic [4:0]          r_rd;
    logic [ADDR_W-1:0]   r_addr0;
    logic [2*XLEN-1:0]   r_wvec;
    logic [2*NB-1:0]     r_mvec;
    logic                r_split;
    logic [XLEN-1:0]     r_beat0;
    logic [XLEN-1:0]     r_beat1;

    logic [OFF_W-1:0]    req_off;
    logic [4:0]          req_size;
    logic                req_legal;
    logic                req_misal;
    logic                req_cross;
    logic                req_err;
    logic                req_split;
    logic [2*XLEN-1:0]   req_wvec;
    logic [2*NB-1:0]     req_mvec;

    logic [XLEN-1:0]     ld_vec;
    logic [XLEN-1:0]     ld_ext;
    logic                ld_sx;

    // Request decode: legality, alignment and the two-beat store data/mask vectors.
    always_comb begin
        req_off  = I_req_addr[OFF_W-1:0];
        req_size = 5'd1 << I_req_funct3[1:0];
        case (I_req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !I_req_we;
            3'b011:                 req_legal = (XLEN == 64);
            3'b110:                 req_legal = (XLEN == 64) && !I_req_we;
            default:                req_legal = 1'b0;
        endcase
        req_misal = ((5'(req_off)) & (req_size - 5'd1)) != 5'd0;
        req_cross = (5'(req_off) + req_size) > 5'(NB);
        req_err   = !req_legal || ((SPLIT_MISALIGNED == 0) && req_misal);
        req_split = (SPLIT_MISALIGNED != 0) && req_cross;
        req_wvec  = {{XLEN{1'b0}}, I_req_wdata} << {req_off, 3'b000};
        req_mvec  = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            if ((5'(i) >= 5'(req_off)) && (5'(i) < 5'(req_off) + req_size)) begin
                req_mvec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state    <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_rd     <= '0;
            r_addr0  <= '0;
            r_wvec   <= '0;
            r_mvec   <= '0;
            r_split  <= 1'b0;
            r_beat0  <= '0;
            r_beat1  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && I_req_valid) begin
                r_we     <= I_req_we;
                r_funct3 <= I_req_funct3;
                r_off    <= req_off;
                r_rd     <= I_req_rd;
                r_addr0  <= {I_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_wvec   <= req_wvec;
                r_mvec   <= req_mvec;
                r_split  <= req_split;
                r_beat0  <= '0;
                r_beat1  <= '0;
            end
            if (state == S_WAIT0 && I_mem_rvalid) begin
                r_beat0 <= I_mem_rdata;
            end
            if (state == S_WAIT1 && I_mem_rvalid) begin
                r_beat1 <= I_mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (I_req_valid) begin
                    state_nxt = req_err ? S_ERR : S_REQ0;
                end
            end
            S_REQ0: begin
                if (I_mem_ready) begin
                    if (!r_we) begin
                        state_nxt = S_WAIT0;
                    end else begin
                        state_nxt = r_split ? S_REQ1 : S_RSP;
                    end
                end
            end
            S_WAIT0: begin
                if (I_mem_rvalid) begin
                    state_nxt = r_split ? S_REQ1 : S_RSP;
                end
            end
            S_REQ1: begin
                if (I_mem_ready) begin
                    state_nxt = r_we ? S_RSP : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (I_mem_rvalid) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load assembly: a single-beat load leaves beat1 at zero from capture.
    always_comb begin
        ld_vec = XLEN'({r_beat1, r_beat0} >> {r_off, 3'b000});
        ld_sx  = !r_funct3[2];
        case (r_funct3[1:0])
            2'b00:   ld_ext = XLEN'(signed'({ld_sx & ld_vec[7], ld_vec[7:0]}));
            2'b01:   ld_ext = XLEN'(signed'({ld_sx & ld_vec[15], ld_vec[15:0]}));
            2'b10:   ld_ext = XLEN'(signed'({ld_sx & ld_vec[31], ld_vec[31:0]}));
            default: ld_ext = ld_vec;
        endcase
    end

    always_comb begin
        O_req_ready = (state == S_IDLE);
        O_mem_valid = 1'b0;
        O_mem_addr  = '0;
        O_mem_we    = 1'b0;
        O_mem_wmask = '0;
        O_mem_wdata = '0;
        O_rsp_valid = 1'b0;
        O_rsp_err   = 1'b0;
        O_rsp_rd    = '0;
        O_rsp_rdata = '0;
        case (state)
            S_REQ0: begin
                O_mem_valid = 1'b1;
                O_mem_addr  = r_addr0;
                O_mem_we    = r_we;
                if (r_we) begin
                    O_mem_wmask = r_mvec[NB-1:0];
                    O_mem_wdata = r_wvec[XLEN-1:0];
                end
            end
            S_REQ1: begin
                O_mem_valid = 1'b1;
                O_mem_addr  = r_addr0 + ADDR_W'(NB);
                O_mem_we    = r_we;
                if (r_we) begin
                    O_mem_wmask = r_mvec[2*NB-1:NB];
                    O_mem_wdata = r_wvec[2*XLEN-1:XLEN];
                end
            end
            S_RSP: begin
                O_rsp_valid = 1'b1;
                O_rsp_rd    = r_rd;
                if (!r_we) begin
                    O_rsp_rdata = ld_ext;
                end
            end
            S_ERR: begin
                O_rsp_valid = 1'b1;
                O_rsp_err   = 1'b1;
                O_rsp_rd    = r_rd;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit placed between the core's EX stage and data memory. It replaces the fixed-width, single-cycle, rotate-only data path with a handshaked, multi-cycle unit that supports XLEN 32/64 and splits word-crossing misaligned accesses into two aligned memory beats. If splitting is disabled, it reports a misalignment error instead.

Parameters:
XLEN, 32, data width; legal values 32 or 64; NB = XLEN/8 bytes per beat
ADDR_W, 32, byte-address width
SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses; 0 = any non-natural alignment returns error

Ports:
I_clk  input  1  clock
I_rst_n  input  1  reset, synchronous, active-low
I_req_valid  input  1  pipeline request valid
O_req_ready  output  1  unit can accept a request
I_req_we  input  1  1 = store, 0 = load
I_req_funct3  input  3  RISC-V load/store funct3
I_req_addr  input  ADDR_W  byte address
I_req_wdata  input  XLEN  store data, right-justified
I_req_rd  input  5  load destination register
O_rsp_valid  output  1  single-cycle completion pulse; no backpressure
O_rsp_rdata  output  XLEN  extended load data; 0 for stores and errors
O_rsp_rd  output  5  rd of the completed request
O_rsp_err  output  1  misaligned or illegal funct3
O_mem_valid  output  1  memory request valid
I_mem_ready  input  1  memory accepts request
O_mem_addr  output  ADDR_W  NB-aligned beat address
O_mem_we  output  1  beat is a write
O_mem_wmask  output  NB  byte enables
O_mem_wdata  output  XLEN  beat write data
I_mem_rvalid  input  1  read data valid; in order, at least 1 cycle after acceptance
I_mem_rdata  input  XLEN  read data

Behaviour:
- Clock and reset: one clock, I_clk. Reset is synchronous, active-low (I_rst_n low at a rising edge).
- Reset state: state = IDLE; O_rsp_valid = 0, O_rsp_rdata = 0, O_rsp_rd = 0, O_rsp_err = 0, O_mem_valid = 0, O_mem_addr = 0, O_mem_we = 0, O_mem_wmask = 0, O_mem_wdata = 0.
- Reset mid-operation: the transaction is dropped and no response is issued. A late I_mem_rvalid is ignored.
- O_req_ready = 1 only in IDLE. A request is captured when I_req_valid & O_req_ready.
- Access size S = 1 << funct3[1:0]. Offset o = addr mod NB.
- Legal funct3: 000, 001, 010, 100, 101. When XLEN = 64, 011 (LD/SD) and 110 (LWU) are also legal.
- Illegal encodings, 1xx stores, 110 or 111 when XLEN = 32, 111 when XLEN = 64: ERR.
- Misalignment when SPLIT_MISALIGNED = 0: o mod S != 0 gives ERR.
- Misalignment when SPLIT_MISALIGNED = 1: accesses with o + S <= NB use one beat; otherwise two beats.
- ERR path: the cycle after capture, O_rsp_valid = 1, O_rsp_err = 1, O_rsp_rdata = 0. No memory traffic.
- Beat 0 address: addr with low log2(NB) bits cleared. Beat 1 address: beat 0 address + NB, modulo 2^ADDR_W (wraps to 0).
- Store data: form a 2*NB-byte vector W = wdata << (8*o) and M = ((1<<S)-1) << o. Beat 0 uses the low halves of W and M; beat 1 uses the high halves. A beat is issued only if its mask is non-zero.
- Load assembly: {beat1, beat0} >> (8*o), truncated to S bytes. funct3[2] = 0 sign-extends to XLEN; funct3[2] = 1 zero-extends. Single-beat loads use beat1 = 0. O_mem_wmask = 0 on read beats.
- FSM states:
  - IDLE: capture request, then go to ERR or REQ0.
  - REQ0: O_mem_valid = 1 and held stable until I_mem_ready. On handshake: a load goes to WAIT0; a store goes to REQ1 if split, else RSP.
  - WAIT0: on I_mem_rvalid, latch beat0; go to REQ1 if split, else RSP.
  - REQ1: issue beat 1; a load goes to WAIT1, a store goes to RSP.
  - WAIT1: on I_mem_rvalid, latch beat1 and go to RSP.
  - RSP: O_rsp_valid = 1 for one cycle, O_rsp_err = 0, then IDLE.
  - ERR: response as defined above, then IDLE.
- Stores are posted: completion is signalled on the final beat acceptance, with no rvalid expected.
- I_mem_rvalid is ignored outside WAIT0 and WAIT1.
- Latency with zero-wait memory (ready high, rvalid the cycle after acceptance), request captured at T:
  - aligned load: O_mem_valid at T+1, rvalid at T+2, O_rsp_valid at T+3
  - aligned store: O_rsp_valid at T+2
  - split load: O_rsp_valid at T+5
  - split store: O_rsp_valid at T+3
  - error: O_rsp_valid at T+1
- O_rsp_rd echoes the captured I_req_rd for every response.

Test Plan:
1. XLEN = 32, LW from 0x100 with mem word 0x8765_4321 -> one beat, addr 0x100, wmask 0000; at T+3 rsp_valid, rdata 0x8765_4321, err 0.
2. LB from 0x103 with word 0x80AA_BBCC -> rdata 0xFFFF_FF80. LBU from the same address -> rdata 0x0000_0080.
3. SPLIT = 1, SW of 0xDDCC_BBAA to 0x0000_0006 -> beat 0 addr 0x4, wmask 1100, wdata 0xBBAA_0000; beat 1 addr 0x8, wmask 0011, wdata 0x0000_DDCC; rsp at T+3.
4. SPLIT = 1, LW from 0xFFFF_FFFE with mem[0xFFFF_FFFC] = 0x1122_3344 and mem[0x0] = 0x5566_7788 -> beat 1 addr 0x0 (wrap); rdata 0x7788_1122.
5. SPLIT = 0, LH from 0x101 -> rsp_valid at T+1, err 1, rdata 0, O_mem_valid never asserted. XLEN = 32 with funct3 = 011 -> err 1.
6. Drop I_rst_n during WAIT0 of a split load, then pulse rvalid after release -> no rsp_valid, O_req_ready = 1, all outputs 0. XLEN = 64 LD from 0x8 returns the full 64-bit word.
